traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Passive checker on the light side of the 4-way junction controller: samples the n/s/e/w light vectors, decodes them back into a phase, and checks encoding, mutual exclusion, phase order and dwell time.
- Sits beside the controller, in simulation or on-chip as a safety watchdog. Its tick input is driven by the same divided clock edge that advances the controller.
- Reports the decoded phase, a lock status, one-cycle error pulses and a saturating error count.

Parameters:
- GREEN_TICKS, 8, required ticks per green phase.
- YELLOW_TICKS, 2, required ticks per yellow phase.
- CNT_W, 4, dwell counter width; must satisfy 2^CNT_W-1 >= max(GREEN_TICKS, YELLOW_TICKS).
- ERRCNT_W, 8, error counter width.

Ports:
- clk_in  in  1  system clock.
- rst_a  in  1  asynchronous, active-high reset.
- tick  in  1  sample enable; one clk_in-wide pulse per controller step.
- n_lights  in  3  north light: 001 green, 010 yellow, 100 red.
- s_lights  in  3  south light, same encoding.
- e_lights  in  3  east light, same encoding.
- w_lights  in  3  west light, same encoding.
- phase  out  3  decoded phase: N=0, N_Y=1, S=2, S_Y=3, E=4, E_Y=5, W=6, W_Y=7.
- locked  out  1  monitor is in LOCKED state.
- dwell  out  CNT_W  ticks spent in the current phase, saturating.
- err_encoding  out  1  pulse: a light vector is not one of 001, 010, 100.
- err_conflict  out  1  pulse: the active-direction count is not exactly one.
- err_sequence  out  1  pulse: an illegal phase successor was observed.
- err_timing  out  1  pulse: a phase ended short, or overran its limit.
- err_count  out  ERRCNT_W  total error pulses, saturating.

Behaviour:
- Reset: all outputs are 0, state is IDLE. rst_a acts immediately, mid-phase included.
- All outputs are registered and update only on clk_in edges with tick=1. On cycles with tick=0, phase, locked, dwell and err_count hold, and all err_* are 0.
- Required cycle order: N -> N_Y -> E -> E_Y -> S -> S_Y -> W -> W_Y -> N.
- Limit per phase: GREEN_TICKS for even codes, YELLOW_TICKS for odd codes.
- Decode:
  - A pattern is legal when all four vectors are valid and exactly one direction is non-red.
  - That direction plus its green/yellow status gives the phase code.
  - Four reds, or two or more non-red directions, is a conflict.
- Error priority when ticked: encoding > conflict > sequence > timing. At most one err_* pulses per tick. err_count increments by 1 on any pulse and saturates at all-ones.
- FSM, evaluated on each tick:
  - Any state, illegal pattern: pulse err_encoding or err_conflict; go to IDLE; phase=0, dwell=0.
  - IDLE, legal pattern: phase=decoded, dwell=1; go to ACQ. No checks are made.
  - ACQ, same phase: dwell++ (saturating). No timing check, because the first dwell is partial.
  - ACQ, decoded phase is the legal successor: phase=new, dwell=1; go to LOCKED. The old dwell is not checked.
  - ACQ, other phase: phase=new, dwell=1; stay in ACQ. No error.
  - LOCKED, same phase, dwell < limit: dwell++.
  - LOCKED, same phase, dwell == limit: pulse err_timing (overrun); dwell++ (saturating); go to ACQ.
  - LOCKED, legal successor, dwell == limit: phase=new, dwell=1; stay LOCKED.
  - LOCKED, legal successor, dwell != limit: pulse err_timing; phase=new, dwell=1; stay LOCKED.
  - LOCKED, non-successor: pulse err_sequence; phase=new, dwell=1; go to ACQ.
- locked=1 only in LOCKED. Latency is one clk_in from a tick edge to updated outputs.
- Dwell saturates at 2^CNT_W-1 and never wraps.

Test Plan:
- Nominal: after reset, drive the controller sequence for 3 full cycles (N green 8 ticks, N_Y 2, E 8, ...) -> locked=1 from the first N->N_Y change; phase follows 0,1,4,5,2,3,6,7; all err_* are 0; err_count=0.
- Encoding: in LOCKED during N, drive n_lights=011 for one tick -> err_encoding=1 for one clk, err_count=1, locked=0, phase=0, dwell=0. Resuming legal N gives ACQ with dwell=1.
- Conflict: in LOCKED during E, drive e=001 and w=001 together -> err_conflict pulse, state IDLE. Same pulse with all four lights at 100.
- Sequence: in LOCKED, go N (8 ticks) directly to S -> err_sequence pulse; phase=2; locked=0. S then S_Y re-locks with no error.
- Timing: in LOCKED, hold N_Y for 1 tick then E -> err_timing on the E tick, locked stays 1. Hold E for 9 ticks -> err_timing on the 9th tick, locked=0.
- Reset and saturation: assert rst_a mid-phase without a clock edge -> outputs clear at once. Force 300 conflict ticks -> err_count holds at 255.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive watchdog for the 4-way junction controller: decodes the light vectors
// into a phase and flags encoding, conflict, sequence and dwell-time violations.
module traffic_light_monitor #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int CNT_W        = 4,
  parameter int ERRCNT_W     = 8
) (
  input  logic                clk_in,
  input  logic                rst_a,
  input  logic                tick,
  input  logic [2:0]          n_lights,
  input  logic [2:0]          s_lights,
  input  logic [2:0]          e_lights,
  input  logic [2:0]          w_lights,
  output logic [2:0]          phase,
  output logic                locked,
  output logic [CNT_W-1:0]    dwell,
  output logic                err_encoding,
  output logic                err_conflict,
  output logic                err_sequence,
  output logic                err_timing,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [CNT_W-1:0] G_LIM = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(YELLOW_TICKS);

  function automatic logic vec_ok(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Controller order N, N_Y, E, E_Y, S, S_Y, W, W_Y (codes 0,1,4,5,2,3,6,7).
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    case (p)
      3'd0:    return 3'd1;
      3'd1:    return 3'd4;
      3'd4:    return 3'd5;
      3'd5:    return 3'd2;
      3'd2:    return 3'd3;
      3'd3:    return 3'd6;
      3'd6:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [2:0]          phase_q, phase_d;
  logic [CNT_W-1:0]    dwell_q, dwell_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic                enc_q, enc_d, conf_q, conf_d, seq_q, seq_d, tim_q, tim_d;

  logic                enc_bad, one_active;
  logic [2:0]          act_cnt, dec_phase;
  logic [CNT_W-1:0]    limit;

  always_comb begin
    enc_bad    = !(vec_ok(n_lights) && vec_ok(s_lights) && vec_ok(e_lights) && vec_ok(w_lights));
    act_cnt    = 3'(n_lights != 3'b100) + 3'(s_lights != 3'b100)
               + 3'(e_lights != 3'b100) + 3'(w_lights != 3'b100);
    one_active = (act_cnt == 3'd1);
    if (n_lights != 3'b100)      dec_phase = {2'd0, n_lights == 3'b010};
    else if (s_lights != 3'b100) dec_phase = {2'd1, s_lights == 3'b010};
    else if (e_lights != 3'b100) dec_phase = {2'd2, e_lights == 3'b010};
    else                         dec_phase = {2'd3, w_lights == 3'b010};
    limit = phase_q[0] ? Y_LIM : G_LIM;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    enc_d   = 1'b0;
    conf_d  = 1'b0;
    seq_d   = 1'b0;
    tim_d   = 1'b0;
    if (tick) begin
      if (enc_bad || !one_active) begin
        enc_d   = enc_bad;
        conf_d  = !enc_bad;
        state_d = IDLE;
        phase_d = 3'd0;
        dwell_d = '0;
      end else begin
        case (state_q)
          ACQ: begin
            if (dec_phase == phase_q) begin
              dwell_d = sat_inc(dwell_q);
            end else begin
              // The first dwell seen after acquisition is partial, so it is never checked.
              phase_d = dec_phase;
              dwell_d = CNT_W'(1);
              if (dec_phase == next_phase(phase_q)) state_d = LOCKED;
            end
          end
          LOCKED: begin
            if (dec_phase == phase_q) begin
              dwell_d = sat_inc(dwell_q);
              if (dwell_q == limit) begin
                tim_d   = 1'b1;
                state_d = ACQ;
              end
            end else begin
              phase_d = dec_phase;
              dwell_d = CNT_W'(1);
              if (dec_phase == next_phase(phase_q)) begin
                tim_d = (dwell_q != limit);
              end else begin
                seq_d   = 1'b1;
                state_d = ACQ;
              end
            end
          end
          default: begin
            phase_d = dec_phase;
            dwell_d = CNT_W'(1);
            state_d = ACQ;
          end
        endcase
      end
    end
    errcnt_d = errcnt_q;
    if ((enc_d || conf_d || seq_d || tim_d) && !(&errcnt_q)) errcnt_d = errcnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_a) begin
    if (rst_a) begin
      state_q  <= IDLE;
      phase_q  <= 3'd0;
      dwell_q  <= '0;
      errcnt_q <= '0;
      enc_q    <= 1'b0;
      conf_q   <= 1'b0;
      seq_q    <= 1'b0;
      tim_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      errcnt_q <= errcnt_d;
      enc_q    <= enc_d;
      conf_q   <= conf_d;
      seq_q    <= seq_d;
      tim_q    <= tim_d;
    end
  end

  assign phase        = phase_q;
  assign locked       = (state_q == LOCKED);
  assign dwell        = dwell_q;
  assign err_encoding = enc_q;
  assign err_conflict = conf_q;
  assign err_sequence = seq_q;
  assign err_timing   = tim_q;
  assign err_count    = errcnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;
  logic       clk_in = 1'b0;
  logic       rst_a  = 1'b1;
  logic       tick   = 1'b0;
  logic [2:0] n_l = 3'b100, s_l = 3'b100, e_l = 3'b100, w_l = 3'b100;
  logic [2:0] phase;
  logic       locked;
  logic [3:0] dwell;
  logic       err_encoding, err_conflict, err_sequence, err_timing;
  logic [7:0] err_count;
  int total = 0;
  int bad   = 0;

  traffic_light_monitor #(.GREEN_TICKS(8), .YELLOW_TICKS(2), .CNT_W(4), .ERRCNT_W(8)) dut (
    .clk_in(clk_in), .rst_a(rst_a), .tick(tick),
    .n_lights(n_l), .s_lights(s_l), .e_lights(e_l), .w_lights(w_l),
    .phase(phase), .locked(locked), .dwell(dwell),
    .err_encoding(err_encoding), .err_conflict(err_conflict),
    .err_sequence(err_sequence), .err_timing(err_timing), .err_count(err_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic set_phase(input logic [2:0] p);
    logic [2:0] act;
    act = p[0] ? 3'b010 : 3'b001;
    n_l = 3'b100; s_l = 3'b100; e_l = 3'b100; w_l = 3'b100;
    case (p[2:1])
      2'd0: n_l = act;
      2'd1: s_l = act;
      2'd2: e_l = act;
      default: w_l = act;
    endcase
  endtask

  task automatic pulse_phase(input logic [2:0] p);
    @(negedge clk_in);
    set_phase(p);
    tick = 1'b1;
    @(posedge clk_in);
    #1 tick = 1'b0;
  endtask

  task automatic pulse_raw(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e, input logic [2:0] w);
    @(negedge clk_in);
    n_l = n; s_l = s; e_l = e; w_l = w;
    tick = 1'b1;
    @(posedge clk_in);
    #1 tick = 1'b0;
  endtask

  task automatic run_phase(input logic [2:0] p, input int cnt);
    for (int i = 0; i < cnt; i++) pulse_phase(p);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_in);
    #1;
    total++; if (phase !== 3'd0)     begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    total++; if (locked !== 1'b0)    begin bad++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    total++; if (dwell !== 4'd0)     begin bad++; $display("FAIL reset_dwell got=%0d exp=0", dwell); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
    @(negedge clk_in) rst_a = 1'b0;
  endtask

  task automatic test_nominal;
    logic [2:0] order [8];
    int len;
    logic exp_lock;
    order = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        len = order[i][0] ? 2 : 8;
        exp_lock = !(c == 0 && i == 0);
        for (int k = 0; k < len; k++) begin
          pulse_phase(order[i]);
          total++; if (phase !== order[i]) begin bad++; $display("FAIL nom_phase c=%0d i=%0d got=%0d exp=%0d", c, i, phase, order[i]); end
          total++; if (dwell !== 4'(k + 1)) begin bad++; $display("FAIL nom_dwell c=%0d i=%0d got=%0d exp=%0d", c, i, dwell, k + 1); end
          total++; if (locked !== exp_lock) begin bad++; $display("FAIL nom_locked c=%0d i=%0d got=%0b exp=%0b", c, i, locked, exp_lock); end
          total++; if ({err_encoding, err_conflict, err_sequence, err_timing} !== 4'b0000) begin
            bad++; $display("FAIL nom_err c=%0d i=%0d got=%b exp=0000", c, i, {err_encoding, err_conflict, err_sequence, err_timing});
          end
        end
      end
    end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL nom_errcnt got=%0d exp=0", err_count); end
  endtask

  task automatic test_encoding;
    run_phase(3'd0, 3);
    total++; if (locked !== 1'b1 || dwell !== 4'd3) begin bad++; $display("FAIL enc_pre got=%0b/%0d exp=1/3", locked, dwell); end
    pulse_raw(3'b011, 3'b100, 3'b100, 3'b100);
    total++; if (err_encoding !== 1'b1) begin bad++; $display("FAIL enc_pulse got=%0b exp=1", err_encoding); end
    total++; if (err_conflict !== 1'b0) begin bad++; $display("FAIL enc_prio got=%0b exp=0", err_conflict); end
    total++; if (err_count !== 8'd1)    begin bad++; $display("FAIL enc_errcnt got=%0d exp=1", err_count); end
    total++; if (locked !== 1'b0 || phase !== 3'd0 || dwell !== 4'd0) begin
      bad++; $display("FAIL enc_state got=%0b/%0d/%0d exp=0/0/0", locked, phase, dwell);
    end
    @(negedge clk_in) n_l = 3'b111;
    @(posedge clk_in);
    #1;
    total++; if (err_encoding !== 1'b0) begin bad++; $display("FAIL enc_clear got=%0b exp=0", err_encoding); end
    total++; if (err_count !== 8'd1)    begin bad++; $display("FAIL enc_hold got=%0d exp=1", err_count); end
    pulse_phase(3'd0);
    total++; if (locked !== 1'b0 || phase !== 3'd0 || dwell !== 4'd1) begin
      bad++; $display("FAIL enc_resume got=%0b/%0d/%0d exp=0/0/1", locked, phase, dwell);
    end
  endtask

  task automatic test_conflict;
    run_phase(3'd1, 2);
    run_phase(3'd4, 2);
    total++; if (locked !== 1'b1 || phase !== 3'd4) begin bad++; $display("FAIL conf_pre got=%0b/%0d exp=1/4", locked, phase); end
    pulse_raw(3'b100, 3'b100, 3'b001, 3'b001);
    total++; if (err_conflict !== 1'b1 || err_encoding !== 1'b0) begin
      bad++; $display("FAIL conf_two got=%0b%0b exp=10", err_conflict, err_encoding);
    end
    total++; if (locked !== 1'b0 || phase !== 3'd0 || dwell !== 4'd0) begin
      bad++; $display("FAIL conf_state got=%0b/%0d/%0d exp=0/0/0", locked, phase, dwell);
    end
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL conf_errcnt got=%0d exp=2", err_count); end
    pulse_raw(3'b100, 3'b100, 3'b100, 3'b100);
    total++; if (err_conflict !== 1'b1 || err_count !== 8'd3) begin
      bad++; $display("FAIL conf_allred got=%0b/%0d exp=1/3", err_conflict, err_count);
    end
  endtask

  task automatic test_sequence;
    run_phase(3'd7, 1);
    run_phase(3'd0, 8);
    total++; if (locked !== 1'b1 || dwell !== 4'd8) begin bad++; $display("FAIL seq_pre got=%0b/%0d exp=1/8", locked, dwell); end
    pulse_phase(3'd2);
    total++; if (err_sequence !== 1'b1 || err_timing !== 1'b0) begin
      bad++; $display("FAIL seq_pulse got=%0b%0b exp=10", err_sequence, err_timing);
    end
    total++; if (phase !== 3'd2 || locked !== 1'b0 || dwell !== 4'd1) begin
      bad++; $display("FAIL seq_state got=%0d/%0b/%0d exp=2/0/1", phase, locked, dwell);
    end
    total++; if (err_count !== 8'd4) begin bad++; $display("FAIL seq_errcnt got=%0d exp=4", err_count); end
    run_phase(3'd2, 7);
    pulse_phase(3'd3);
    total++; if (locked !== 1'b1 || phase !== 3'd3 || dwell !== 4'd1) begin
      bad++; $display("FAIL seq_relock got=%0b/%0d/%0d exp=1/3/1", locked, phase, dwell);
    end
    total++; if (err_count !== 8'd4) begin bad++; $display("FAIL seq_relock_cnt got=%0d exp=4", err_count); end
  endtask

  task automatic test_timing;
    run_phase(3'd3, 1);
    run_phase(3'd6, 8);
    run_phase(3'd7, 2);
    run_phase(3'd0, 8);
    total++; if (locked !== 1'b1 || err_count !== 8'd4) begin bad++; $display("FAIL tim_pre got=%0b/%0d exp=1/4", locked, err_count); end
    pulse_phase(3'd1);
    pulse_phase(3'd4);
    total++; if (err_timing !== 1'b1 || locked !== 1'b1) begin bad++; $display("FAIL tim_short got=%0b/%0b exp=1/1", err_timing, locked); end
    total++; if (phase !== 3'd4 || dwell !== 4'd1 || err_count !== 8'd5) begin
      bad++; $display("FAIL tim_short_st got=%0d/%0d/%0d exp=4/1/5", phase, dwell, err_count);
    end
    run_phase(3'd4, 7);
    total++; if (err_timing !== 1'b0 || dwell !== 4'd8 || locked !== 1'b1) begin
      bad++; $display("FAIL tim_full got=%0b/%0d/%0b exp=0/8/1", err_timing, dwell, locked);
    end
    pulse_phase(3'd4);
    total++; if (err_timing !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL tim_over got=%0b/%0b exp=1/0", err_timing, locked); end
    total++; if (dwell !== 4'd9 || err_count !== 8'd6) begin bad++; $display("FAIL tim_over_st got=%0d/%0d exp=9/6", dwell, err_count); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk_in);
    #3 rst_a = 1'b1;
    #1;
    total++; if (phase !== 3'd0 || dwell !== 4'd0) begin bad++; $display("FAIL rst_mid got=%0d/%0d exp=0/0", phase, dwell); end
    total++; if (locked !== 1'b0 || err_count !== 8'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0b/%0d exp=0/0", locked, err_count); end
    @(negedge clk_in) rst_a = 1'b0;
  endtask

  task automatic test_dwell_sat;
    run_phase(3'd4, 15);
    total++; if (dwell !== 4'd15 || locked !== 1'b0) begin bad++; $display("FAIL dsat_15 got=%0d/%0b exp=15/0", dwell, locked); end
    run_phase(3'd4, 5);
    total++; if (dwell !== 4'd15) begin bad++; $display("FAIL dsat_hold got=%0d exp=15", dwell); end
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL dsat_err got=%0d exp=0", err_count); end
  endtask

  task automatic test_errcnt_sat;
    for (int i = 0; i < 300; i++) pulse_raw(3'b100, 3'b100, 3'b100, 3'b100);
    total++; if (err_count !== 8'd255 || err_conflict !== 1'b1) begin
      bad++; $display("FAIL esat got=%0d/%0b exp=255/1", err_count, err_conflict);
    end
    @(posedge clk_in);
    #1;
    total++; if (err_conflict !== 1'b0 || err_count !== 8'd255) begin
      bad++; $display("FAIL esat_idle got=%0b/%0d exp=0/255", err_conflict, err_count);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_encoding;
    test_conflict;
    test_sequence;
    test_timing;
    test_reset_mid;
    test_dwell_sat;
    test_errcnt_sat;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
